mod_counter: RTL and testbench



---
 rtl/mod_counter.sv | 89 ++++++++
 tb/tb_mod_counter.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/mod_counter.sv
// Synchronous modulo-MODULUS up/down counter with parallel load, synchronous clear,
// terminal-count and wrap outputs for synchronous cascading, and a sticky load-range error flag.
module mod_counter #(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 16
) (
  input  logic             clk,
  input  logic             clear_n,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             sync_clr,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             wrap,
  output logic             load_err
);

  generate
    if (MODULUS < 2 || longint'(MODULUS) > (64'd1 << WIDTH)) begin : g_bad_modulus
      $error("mod_counter: MODULUS must satisfy 2 <= MODULUS <= 2**WIDTH");
    end
  endgenerate

  // MAX_VAL always fits in WIDTH bits; the range test uses one extra bit so MODULUS==2**WIDTH works.
  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);

  logic [WIDTH-1:0] count_reg, count_next;
  logic             wrap_reg, wrap_next;
  logic             load_err_reg, load_err_next;
  logic             at_max, at_zero, load_oor;

  assign at_max   = (count_reg == MAX_VAL);
  assign at_zero  = (count_reg == '0);
  assign load_oor = ({1'b0, load_val} >= MOD_EXT);

  always_comb begin
    count_next    = count_reg;
    wrap_next     = 1'b0;
    load_err_next = load_err_reg;
    if (sync_clr) begin
      count_next = '0;
    end else if (load) begin
      if (load_oor) begin
        count_next    = MAX_VAL;
        load_err_next = 1'b1;
      end else begin
        count_next = load_val;
      end
    end else if (en) begin
      if (up_dn) begin
        if (at_max) begin
          count_next = '0;
          wrap_next  = 1'b1;
        end else begin
          count_next = count_reg + WIDTH'(1);
        end
      end else begin
        if (at_zero) begin
          count_next = MAX_VAL;
          wrap_next  = 1'b1;
        end else begin
          count_next = count_reg - WIDTH'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      count_reg    <= '0;
      wrap_reg     <= 1'b0;
      load_err_reg <= 1'b0;
    end else begin
      count_reg    <= count_next;
      wrap_reg     <= wrap_next;
      load_err_reg <= load_err_next;
    end
  end

  // tc depends on the live direction so a cascade enable (en & tc) follows direction flips at once.
  assign tc       = up_dn ? at_max : at_zero;
  assign count    = count_reg;
  assign wrap     = wrap_reg;
  assign load_err = load_err_reg;

endmodule

// File: tb/tb_mod_counter.sv
// Scoreboard bench for mod_counter: a MODULUS=10 and a MODULUS=16 instance share stimulus;
// expected values come from a reference model and are queued at drive time, compared after the edge.
module tb_mod_counter;

  logic       clk = 1'b0;
  logic       clear_n = 1'b0;
  logic       en = 1'b0, up_dn = 1'b1, load = 1'b0, sync_clr = 1'b0;
  logic [3:0] load_val = 4'd0;
  logic [3:0] count10, count16;
  logic       tc10, tc16, wrap10, wrap16, err10, err16;

  int checks = 0;
  int failures = 0;
  int txn = 0;

  typedef struct {
    int cnt[2];
    int wrp[2];
    int err[2];
    int tcv[2];
  } exp_t;

  exp_t sb[$];
  int   m_cnt[2];
  int   m_wrap[2];
  int   m_err[2];
  int   mods[2] = '{10, 16};
  int   up_seq[12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};

  always #5 clk = ~clk;

  mod_counter #(.WIDTH(4), .MODULUS(10)) u_m10 (
    .clk(clk), .clear_n(clear_n), .en(en), .up_dn(up_dn), .load(load),
    .load_val(load_val), .sync_clr(sync_clr),
    .count(count10), .tc(tc10), .wrap(wrap10), .load_err(err10)
  );

  mod_counter #(.WIDTH(4), .MODULUS(16)) u_m16 (
    .clk(clk), .clear_n(clear_n), .en(en), .up_dn(up_dn), .load(load),
    .load_val(load_val), .sync_clr(sync_clr),
    .count(count16), .tc(tc16), .wrap(wrap16), .load_err(err16)
  );

  task automatic check_eq(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_cnt[k]  = 0;
      m_wrap[k] = 0;
      m_err[k]  = 0;
    end
  endtask

  task automatic model_update(input int k, input bit e, input bit ud, input bit ld,
                              input int lv, input bit sc);
    int m;
    m = mods[k];
    m_wrap[k] = 0;
    if (sc) begin
      m_cnt[k] = 0;
    end else if (ld) begin
      if (lv < m) m_cnt[k] = lv;
      else begin
        m_cnt[k] = m - 1;
        m_err[k] = 1;
      end
    end else if (e) begin
      if (ud) begin
        m_wrap[k] = (m_cnt[k] == m - 1) ? 1 : 0;
        m_cnt[k]  = (m_cnt[k] + 1) % m;
      end else begin
        m_wrap[k] = (m_cnt[k] == 0) ? 1 : 0;
        m_cnt[k]  = (m_cnt[k] + m - 1) % m;
      end
    end
  endtask

  task automatic check_reset_state(input string tag);
    check_eq({tag, "_cnt10"}, int'(count10), 0);
    check_eq({tag, "_wrap10"}, int'(wrap10), 0);
    check_eq({tag, "_err10"}, int'(err10), 0);
    check_eq({tag, "_cnt16"}, int'(count16), 0);
    check_eq({tag, "_wrap16"}, int'(wrap16), 0);
    check_eq({tag, "_err16"}, int'(err16), 0);
  endtask

  task automatic step(input bit e, input bit ud, input bit ld, input int lv, input bit sc);
    exp_t ex;
    exp_t got_exp;
    en       = e;
    up_dn    = ud;
    load     = ld;
    load_val = 4'(lv);
    sync_clr = sc;
    for (int k = 0; k < 2; k++) begin
      model_update(k, e, ud, ld, lv, sc);
      ex.cnt[k] = m_cnt[k];
      ex.wrp[k] = m_wrap[k];
      ex.err[k] = m_err[k];
      ex.tcv[k] = ud ? int'(m_cnt[k] == mods[k] - 1) : int'(m_cnt[k] == 0);
    end
    sb.push_back(ex);
    @(posedge clk);
    #1;
    got_exp = sb.pop_front();
    txn++;
    $display("txn %0d en=%0b ud=%0b ld=%0b lv=%0d clr=%0b cnt10=%0d wrap10=%0b cnt16=%0d wrap16=%0b",
             txn, e, ud, ld, lv, sc, count10, wrap10, count16, wrap16);
    check_eq("cnt10", int'(count10), got_exp.cnt[0]);
    check_eq("wrap10", int'(wrap10), got_exp.wrp[0]);
    check_eq("err10", int'(err10), got_exp.err[0]);
    check_eq("tc10", int'(tc10), got_exp.tcv[0]);
    check_eq("cnt16", int'(count16), got_exp.cnt[1]);
    check_eq("wrap16", int'(wrap16), got_exp.wrp[1]);
    check_eq("err16", int'(err16), got_exp.err[1]);
    check_eq("tc16", int'(tc16), got_exp.tcv[1]);
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_reset_state("por");
    @(negedge clk);
    clear_n = 1'b1;

    // Activity: out-of-range load on m10, then count up to 7 on m10.
    step(1'b0, 1'b1, 1'b1, 12, 1'b0);
    check_eq("oor_cnt10", int'(count10), 9);
    check_eq("oor_err10", int'(err10), 1);
    for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 1'b0, 0, 1'b0);
    check_eq("pre_rst_cnt10", int'(count10), 7);

    // Asynchronous reset between edges.
    #3;
    clear_n = 1'b0;
    #1;
    model_reset();
    check_reset_state("async");
    @(negedge clk);
    clear_n = 1'b1;

    // Up wrap, 12 edges from 0.
    for (int i = 0; i < 12; i++) begin
      step(1'b1, 1'b1, 1'b0, 0, 1'b0);
      check_eq("upseq10", int'(count10), up_seq[i]);
      check_eq("upseq_wrap10", int'(wrap10), int'(up_seq[i] == 0));
    end

    // Down wrap: load 2, then 1,0,9,8.
    step(1'b0, 1'b0, 1'b1, 2, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, 0, 1'b0);
    check_eq("down_end10", int'(count10), 8);

    // Priority: sync_clr over load over en, then load over en.
    step(1'b1, 1'b1, 1'b1, 5, 1'b1);
    check_eq("prio_clr10", int'(count10), 0);
    step(1'b1, 1'b1, 1'b1, 5, 1'b0);
    check_eq("prio_load10", int'(count10), 5);

    // load_err stickiness through sync_clr and later in-range loads.
    step(1'b0, 1'b1, 1'b1, 12, 1'b0);
    step(1'b0, 1'b1, 1'b0, 0, 1'b1);
    step(1'b0, 1'b1, 1'b1, 3, 1'b0);
    check_eq("sticky_err10", int'(err10), 1);
    check_eq("sticky_cnt10", int'(count10), 3);

    // Full-range counter: 14 -> 15, 0 (wrap), 1, flip down -> 0, 15 (wrap), then hold.
    step(1'b0, 1'b1, 1'b1, 14, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 0, 1'b0);
    check_eq("full_up16", int'(count16), 1);
    step(1'b1, 1'b0, 1'b0, 0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 0, 1'b0);
    check_eq("full_dn16", int'(count16), 15);
    check_eq("full_dn_wrap16", int'(wrap16), 1);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 0, 1'b0);
    check_eq("hold16", int'(count16), 15);

    // Random mix of controls.
    for (int i = 0; i < 60; i++) begin
      step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 9) == 0), int'($urandom_range(0, 15)),
           1'($urandom_range(0, 14) == 0));
    end

    // Final reset clears the sticky flag.
    @(negedge clk);
    clear_n = 1'b0;
    #1;
    model_reset();
    check_reset_state("final");
    @(negedge clk);
    clear_n = 1'b1;
    step(1'b1, 1'b1, 1'b0, 0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
